// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage bus for the HI/LO multiply/divide sequencer.
// The EX/ID side issues operations; the unit returns HI/LO and pipeline status.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [2:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             hiloreadD;
  logic             muldivD;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stallhilo;

  modport master (
    output startE, opE, srcaE, srcbE, hiloreadD, muldivD, cancel,
    input  hi, lo, busy, done, stallhilo
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, hiloreadD, muldivD, cancel,
    output hi, lo, busy, done, stallhilo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative multiply/divide sequencer that owns the HI/LO register pair.
// Signed operations run on magnitudes; the sign fix-up happens in a final
// FIX cycle that also commits the result to HI/LO.
module hilo_muldiv_ctrl #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = WIDTH'(32'hFFFFFFFF)
) (
  input  logic                  clk,
  input  logic                  reset,
  hilo_muldiv_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic               busy;

  // ops 0 (mult) and 2 (div) are signed; work on operand magnitudes
  assign is_signed = ~bus.opE[0];
  assign a_neg     = is_signed & bus.srcaE[WIDTH-1];
  assign b_neg     = is_signed & bus.srcbE[WIDTH-1];
  assign abs_a     = a_neg ? (~bus.srcaE + 1'b1) : bus.srcaE;
  assign abs_b     = b_neg ? (~bus.srcbE + 1'b1) : bus.srcbE;

  // state register: every flop loads its _d value, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // next-state and datapath: start/latch in IDLE, iterate in RUN, sign-fix and commit in FIX
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    prod      = '0;
    unique case (state_q)
      IDLE: begin
        if (!bus.cancel && bus.startE) begin
          case (bus.opE)
            3'd4: hi_d = bus.srcaE;
            3'd5: lo_d = bus.srcaE;
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d = bus.opE[1];
              opnd_d   = bus.opE[1] ? abs_b : abs_a;
              cnt_d    = '0;
              if (bus.opE[1] && (bus.srcbE == '0)) begin
                acc_d     = {{WIDTH{1'b0}}, DIV0_LO};
                rem_d     = bus.srcaE;
                neg_res_d = 1'b0;
                neg_rem_d = 1'b0;
                state_d   = FIX;
              end else begin
                acc_d     = {{WIDTH{1'b0}}, (bus.opE[1] ? abs_a : abs_b)};
                rem_d     = '0;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                state_d   = RUN;
              end
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (is_div_q) begin
            div_shift = {rem_q, acc_q[WIDTH-1]};
            div_diff  = div_shift - {1'b0, opnd_q};
            rem_d     = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_d     = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
            acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
          end else begin
            prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs: busy while an operation is in flight, stall only if a later op needs the unit
  always_comb begin
    busy          = (state_q != IDLE);
    bus.busy      = busy;
    bus.stallhilo = busy & (bus.hiloreadD | bus.muldivD);
    bus.hi        = hi_q;
    bus.lo        = lo_q;
    bus.done      = done_q;
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed test-plan steps followed by
// randomized operations, all compared against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  int   stall_cnt;
  int   lat;
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  logic [63:0] r;
  string cur_step;

  hilo_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(32), .DIV0_LO(32'hFFFFFFFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: full-width arithmetic, SV '/' and '%' truncate toward zero like MIPS
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, q, rr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return 64'(ua * ub);
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q  = sa / sb;
        rr = sa % sb;
        return {32'(rr), 32'(q)};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {model_hi, model_lo};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s/%s: observed=0x%08h expected=0x%08h", cur_step, tag, obs, exp);
  endtask

  // present one op for a single edge (edge 0)
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.startE = 1'b1;
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    tick();
    bus.startE = 1'b0;
  endtask

  // count busy samples until busy drops, bounded so a stuck DUT still ends
  task automatic waitDone(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (bus.stallhilo === 1'b1) stall_cnt++;
      tick();
    end
  endtask

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    if (op <= 3'd3) begin
      r = refResult(op, a, b);
      model_hi = r[63:32];
      model_lo = r[31:0];
    end else if (op == 3'd4) begin
      model_hi = a;
    end else if (op == 3'd5) begin
      model_lo = a;
    end
    applyStimulus(op, a, b);
    if (op <= 3'd3) begin
      waitDone(n);
      checkOutput("latency", n, (op >= 3'd2 && b == 32'd0) ? 32'd1 : 32'd33);
      checkOutput("done_pulse", bus.done, 32'd1);
      checkOutput("stall_done_cycle", bus.stallhilo, 32'd0);
    end else begin
      checkOutput("busy_idle_op", bus.busy, 32'd0);
      checkOutput("done_idle_op", bus.done, 32'd0);
    end
    checkOutput("hi", bus.hi, model_hi);
    checkOutput("lo", bus.lo, model_lo);
    if (op <= 3'd3) begin
      tick();
      checkOutput("done_drop", bus.done, 32'd0);
    end
  endtask

  initial begin
    int sel;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    checks = 0; passes = 0; stall_cnt = 0;
    model_hi = '0; model_lo = '0;
    cur_step = "reset";
    reset = 1'b0;
    bus.startE = 1'b0; bus.opE = '0; bus.srcaE = '0; bus.srcbE = '0;
    bus.hiloreadD = 1'b0; bus.muldivD = 1'b0; bus.cancel = 1'b0;
    tick();
    tick();
    checkOutput("hi", bus.hi, 32'd0);
    checkOutput("lo", bus.lo, 32'd0);
    checkOutput("busy", bus.busy, 32'd0);
    checkOutput("done", bus.done, 32'd0);
    reset = 1'b1;
    tick();

    cur_step = "multu_max";
    runOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput("hi_const", bus.hi, 32'hFFFFFFFE);
    checkOutput("lo_const", bus.lo, 32'h00000001);

    cur_step = "mult_stall";
    bus.hiloreadD = 1'b1;
    stall_cnt = 0;
    runOp(3'd0, 32'hFFFFFFFD, 32'd5);
    checkOutput("stall_cycles", stall_cnt, 32'd33);
    bus.hiloreadD = 1'b0;
    checkOutput("hi_const", bus.hi, 32'hFFFFFFFF);
    checkOutput("lo_const", bus.lo, 32'hFFFFFFF1);

    cur_step = "div_neg7_2";
    runOp(3'd2, 32'hFFFFFFF9, 32'd2);
    checkOutput("hi_const", bus.hi, 32'hFFFFFFFF);
    checkOutput("lo_const", bus.lo, 32'hFFFFFFFD);
    cur_step = "divu_100_7";
    runOp(3'd3, 32'd100, 32'd7);
    checkOutput("hi_const", bus.hi, 32'd2);
    checkOutput("lo_const", bus.lo, 32'd14);
    cur_step = "div_ovf";
    runOp(3'd2, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("hi_const", bus.hi, 32'd0);
    checkOutput("lo_const", bus.lo, 32'h80000000);

    cur_step = "divu_by0";
    runOp(3'd3, 32'h1234, 32'd0);
    checkOutput("hi_const", bus.hi, 32'h1234);
    checkOutput("lo_const", bus.lo, 32'hFFFFFFFF);
    cur_step = "mthi";
    runOp(3'd4, 32'hA5A5A5A5, 32'd0);
    cur_step = "mtlo";
    runOp(3'd5, 32'h5A5A5A5A, 32'd0);
    checkOutput("hi_const", bus.hi, 32'hA5A5A5A5);
    checkOutput("lo_const", bus.lo, 32'h5A5A5A5A);
    cur_step = "op6_noop";
    runOp(3'd6, 32'h77777777, 32'd1);

    cur_step = "start_while_busy";
    r = refResult(3'd0, 32'd12345, 32'hFFFFFD4A);
    model_hi = r[63:32];
    model_lo = r[31:0];
    bus.muldivD = 1'b1;
    stall_cnt = 0;
    applyStimulus(3'd0, 32'd12345, 32'hFFFFFD4A);
    repeat (9) tick();
    applyStimulus(3'd3, 32'd99, 32'd0);
    waitDone(lat);
    bus.muldivD = 1'b0;
    checkOutput("latency", lat, 32'd23);
    checkOutput("stall_cycles", stall_cnt, 32'd23);
    checkOutput("done_pulse", bus.done, 32'd1);
    checkOutput("hi", bus.hi, model_hi);
    checkOutput("lo", bus.lo, model_lo);
    tick();
    checkOutput("done_drop", bus.done, 32'd0);

    cur_step = "cancel_run";
    applyStimulus(3'd1, 32'hDEADBEEF, 32'h01234567);
    repeat (19) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    checkOutput("busy", bus.busy, 32'd0);
    checkOutput("done", bus.done, 32'd0);
    checkOutput("hi", bus.hi, model_hi);
    checkOutput("lo", bus.lo, model_lo);
    tick();
    checkOutput("done_later", bus.done, 32'd0);

    cur_step = "cancel_vs_start";
    bus.cancel = 1'b1;
    applyStimulus(3'd5, 32'h11111111, 32'd0);
    applyStimulus(3'd1, 32'd3, 32'd4);
    bus.cancel = 1'b0;
    checkOutput("busy", bus.busy, 32'd0);
    checkOutput("lo", bus.lo, model_lo);

    cur_step = "reset_mid_div";
    applyStimulus(3'd2, 32'd1000000, 32'd3);
    repeat (14) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_hi = '0;
    model_lo = '0;
    checkOutput("hi", bus.hi, 32'd0);
    checkOutput("lo", bus.lo, 32'd0);
    checkOutput("busy", bus.busy, 32'd0);
    checkOutput("done", bus.done, 32'd0);
    cur_step = "multu_6_7";
    runOp(3'd1, 32'd6, 32'd7);
    checkOutput("hi_const", bus.hi, 32'd0);
    checkOutput("lo_const", bus.lo, 32'd42);

    cur_step = "random";
    stall_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 16));
        2:       rb = 32'd0 - 32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      runOp(rop, ra, rb);
    end
    checkOutput("no_stall_without_request", stall_cnt, 32'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer owning the HI/LO register pair used by the execute stage.
- Accepts mult/multu/div/divu/mthi/mtlo from EX.
- Runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, then commits HI/LO.
- Drives a stall request to the hazard unit while a result is pending and a later instruction needs HI/LO or the unit.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- DIV0_LO, 32'hFFFFFFFF, LO value committed on divide-by-zero. HI receives the dividend.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-low reset
- startE  input  1  valid muldiv/mthi/mtlo op in EX this cycle
- opE  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, others no-op
- srcaE  input  WIDTH  rs operand (multiplicand/dividend/mthi-mtlo data)
- srcbE  input  WIDTH  rt operand (multiplier/divisor)
- hiloreadD  input  1  instruction in ID is mfhi/mflo
- muldivD  input  1  instruction in ID is any op of this unit
- cancel  input  1  abort in-flight operation; HI/LO unchanged
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO just committed by mult/div
- stallhilo  output  1  stall request to hazard unit

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset==0 at a clk edge) forces hi=0, lo=0, busy=0, done=0, state IDLE. This includes mid-operation; partial results are discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - startE with opE 4 sets hi<=srcaE; opE 5 sets lo<=srcaE. Both take one edge, no busy, no done.
  - startE with opE 0-3 latches |a|,|b| (signed ops) or raw operands (unsigned), result signs, and op. Sets counter=0 and goes to RUN.
  - opE 6/7 are ignored.
- RUN:
  - One iteration per edge; counter increments.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on LSB of multiplier.
  - Divide: restoring, one quotient bit per edge, remainder WIDTH+1 bits.
  - After the WIDTH-th iteration (counter==WIDTH-1) go to FIX.
- Divide-by-zero (divisor==0 at start): RUN is skipped. Go directly to FIX with quotient=DIV0_LO and remainder=srcaE, with no sign correction.
- FIX:
  - Signed mult: negate the 2*WIDTH product if operand signs differ.
  - Signed div: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - -2^31 / -1 gives lo=32'h80000000, hi=0.
  - Commit hi<=product[2W-1:W] or remainder, lo<=product[W-1:0] or quotient.
  - Go to IDLE; done=1 in the following cycle only.
- Latency: start sampled at edge 0. RUN occupies edges 1..WIDTH, FIX commits at edge WIDTH+1, and done/new hi/lo are visible after edge WIDTH+1. Divide-by-zero commits at edge 1.
- busy=1 whenever state is RUN or FIX. It drops in the cycle done is high.
- stallhilo = busy & (hiloreadD | muldivD). It is combinational and deasserts in the done cycle, so mfhi reads committed data.
- startE while busy is ignored. The hazard unit guarantees this by stalling; the bench checks it is ignored anyway.
- cancel: in RUN or FIX, return to IDLE next edge with hi/lo unchanged and no done. In IDLE it has no effect.
- cancel and startE in the same IDLE cycle: cancel wins, op dropped.
- Reset has priority over cancel, and cancel over start.
- hi/lo change only on mthi/mtlo, the FIX commit, or reset.

Test Plan:
- Reset, then multu 0xFFFFFFFF*0xFFFFFFFF: busy for 33 cycles, done pulse after edge 33, hi=0xFFFFFFFE, lo=0x00000001.
- mult -3*5: hi=0xFFFFFFFF, lo=0xFFFFFFF1. With hiloreadD held high, stallhilo=1 through edge 33 and 0 in the done cycle.
- div -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 100/7: lo=14, hi=2. Then div 0x80000000/-1: lo=0x80000000, hi=0.
- divu 0x1234/0: done after edge 1, lo=0xFFFFFFFF, hi=0x1234. mthi 0xA5A5A5A5 then mtlo 0x5A5A5A5A: hi/lo update in one edge each, busy stays 0.
- Second startE on cycle 10 of a mult: ignored, result equals a single-op run. cancel on cycle 20: busy=0 next cycle, no done, hi/lo keep prior values.
- reset=0 for one edge at cycle 15 of a div: hi=lo=0, busy=0. A new multu 6*7 afterwards gives lo=42, hi=0.
